// File: rtl/i2c_touch_target.sv
// I2C target emulating the MPR121 subset used by our master: soft reset, ECR and touch status.
// Optional open-drain interrupt output is enabled with `define I2C_TOUCH_TARGET_IRQ_EN.
`timescale 1ns/1ps
module i2c_touch_target #(
  parameter logic [6:0] ADDR       = 7'h5A,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk_27M,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  input  logic [11:0] touch,
  output logic [7:0]  ecr,
  output logic        soft_reset_pulse,
  output logic        busy
`ifdef I2C_TOUCH_TARGET_IRQ_EN
  ,
  output logic        irq_n
`endif
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_D, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    pin, sync1, sync2, filt, filt_d;
  logic [CW-1:0] cnt [2];
  logic          scl_f, sda_f, scl_d, sda_d;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg, ptr, byte_in, rd_byte;
  logic          rw, addr_match, snap_take;
  logic [11:0]   snap, masked, en_mask;
  logic [3:0]    n_en;

  assign sda_o = 1'b0;
  assign pin   = {scl_i, sda_i};

  // Per-line synchronizer, then a level is accepted only after FILTER_LEN equal samples.
  always_ff @(posedge clk_27M) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_d     = filt_d[1];
  assign sda_d     = filt_d[0];
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & ~sda_f & sda_d;
  assign stop_det  = scl_f & scl_d & sda_f & ~sda_d;

  assign byte_in    = {shreg[6:0], sda_f};
  assign addr_match = (shreg[6:0] == ADDR);
  assign snap_take  = (state == S_ADDR) && scl_rise && (bit_cnt == 4'd7) && addr_match && sda_f;

  // Only the first min(ecr[3:0], 12) electrodes report touches.
  always_comb begin
    en_mask = '0;
    n_en    = (ecr[3:0] > 4'd12) ? 4'd12 : ecr[3:0];
    for (int i = 0; i < 12; i++) en_mask[i] = (4'(i) < n_en);
    masked = touch & en_mask;
  end

  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      8'h00:   rd_byte = snap[7:0];
      8'h01:   rd_byte = {4'h0, snap[11:8]};
      8'h5E:   rd_byte = ecr;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_27M) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Bus conditions override the bit FSM; otherwise state only advances on SCL rising edges.
  always_comb begin
    state_n = state;
    if (start_det) begin
      state_n = S_ADDR;
    end else if (stop_det) begin
      state_n = S_IDLE;
    end else if (scl_rise) begin
      case (state)
        S_ADDR:  if (bit_cnt == 4'd7) state_n = addr_match ? S_ACK_A : S_IGNORE;
        S_ACK_A: state_n = rw ? S_RDATA : S_REG;
        S_REG:   if (bit_cnt == 4'd7) state_n = S_ACK_D;
        S_WDATA: if (bit_cnt == 4'd7) state_n = S_ACK_D;
        S_ACK_D: state_n = S_WDATA;
        S_RDATA: if (bit_cnt == 4'd8 && sda_f) state_n = S_IGNORE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk_27M) begin
    if (reset) begin
      sda_t            <= 1'b1;
      ecr              <= 8'h00;
      soft_reset_pulse <= 1'b0;
      busy             <= 1'b0;
      ptr              <= 8'h00;
      bit_cnt          <= 4'd0;
      shreg            <= 8'h00;
      rw               <= 1'b0;
      snap             <= 12'h000;
    end else begin
      soft_reset_pulse <= 1'b0;
      if (start_det) begin
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
      end else if (stop_det) begin
        sda_t <= 1'b1;
        busy  <= 1'b0;
      end else begin
        if (scl_rise) begin
          case (state)
            S_ADDR: begin
              shreg <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                rw      <= sda_f;
                if (addr_match) busy <= 1'b1;
                if (snap_take)  snap <= masked;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            S_REG: begin
              shreg <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ptr     <= byte_in;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            S_WDATA: begin
              shreg <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                ptr     <= ptr + 8'd1;
                if (ptr == 8'h5E) begin
                  ecr <= byte_in;
                end else if (ptr == 8'h80 && byte_in == 8'h63) begin
                  ecr              <= 8'h00;
                  soft_reset_pulse <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            S_RDATA: begin
              // Ninth edge carries the master's ACK (low) or NACK (high).
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                if (!sda_f) ptr <= ptr + 8'd1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            S_ACK_A, S_ACK_D: sda_t <= 1'b0;
            S_RDATA:          sda_t <= (bit_cnt == 4'd8) ? 1'b1 : rd_byte[3'd7 - bit_cnt[2:0]];
            default:          sda_t <= 1'b1;
          endcase
        end
      end
    end
  end

`ifdef I2C_TOUCH_TARGET_IRQ_EN
  logic [11:0] last_read;

  // A read addressed at 0x00 acknowledges the interrupt and becomes the new reference.
  always_ff @(posedge clk_27M) begin
    if (reset) begin
      irq_n     <= 1'b1;
      last_read <= 12'h000;
    end else if (snap_take && ptr == 8'h00) begin
      irq_n     <= 1'b1;
      last_read <= masked;
    end else if (masked != last_read) begin
      irq_n <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_touch_target.sv
// Bench for i2c_touch_target: bit-banged I2C master, wired-AND SDA, behavioural register model.
`timescale 1ns/1ps
module tb_i2c_touch_target;

  localparam int         Q      = 8;
  localparam logic [6:0] ADDR_T = 7'h5A;

  logic        clk_27M = 1'b0;
  logic        reset   = 1'b1;
  logic        scl_m   = 1'b1;
  logic        sda_m   = 1'b1;
  logic        scl_i, sda_i, sda_o, sda_t, soft_reset_pulse, busy;
  logic [11:0] touch = 12'h000;
  logic [7:0]  ecr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int pulse_cnt = 0, pulse_run = 0, pulse_max = 0, drive_cnt = 0;
  logic [7:0] m_ecr = 8'h00;

  assign scl_i = scl_m;
  assign sda_i = sda_m & (sda_t | sda_o);

  i2c_touch_target #(.ADDR(ADDR_T), .FILTER_LEN(3)) dut (
    .clk_27M(clk_27M), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_o(sda_o), .sda_t(sda_t), .touch(touch), .ecr(ecr),
    .soft_reset_pulse(soft_reset_pulse), .busy(busy)
  );

  // Clock / reset
  always #18.5 clk_27M = ~clk_27M;

  always @(negedge clk_27M) begin
    if (soft_reset_pulse) begin
      pulse_cnt++;
      pulse_run++;
      if (pulse_run > pulse_max) pulse_max = pulse_run;
    end else begin
      pulse_run = 0;
    end
    if (!sda_t) drive_cnt++;
  end

  initial begin
    repeat (150000) @(posedge clk_27M);
    $display("FAIL watchdog: got no end of test, required end within 150000 cycles");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [11:0] model_snap(input logic [11:0] t, input logic [7:0] e);
    int n;
    n = (e[3:0] > 4'd12) ? 12 : int'(e[3:0]);
    return t & 12'((1 << n) - 1);
  endfunction

  function automatic logic [7:0] model_reg(input logic [7:0] a, input logic [11:0] s);
    if (a == 8'h00) return s[7:0];
    if (a == 8'h01) return {4'h0, s[11:8]};
    if (a == 8'h5E) return m_ecr;
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h5E) m_ecr = d;
    else if (a == 8'h80 && d == 8'h63) m_ecr = 8'h00;
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_27M);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(2 * Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = sda_i; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic do_write(input logic [7:0] ptr, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    put_byte({ADDR_T, 1'b0}, a); if (!a) nacks++;
    put_byte(ptr, a);            if (!a) nacks++;
    foreach (tx_q[i]) begin
      put_byte(tx_q[i], a); if (!a) nacks++;
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n, output int nacks,
                         output logic busy_mid, output logic sdat_end);
    logic a;
    logic [7:0] d;
    nacks = 0;
    rx_q.delete();
    i2c_start();
    put_byte({ADDR_T, 1'b0}, a); if (!a) nacks++;
    busy_mid = busy;
    put_byte(ptr, a);            if (!a) nacks++;
    i2c_start();
    put_byte({ADDR_T, 1'b1}, a); if (!a) nacks++;
    for (int i = 0; i < n; i++) begin
      get_byte(d, i < n - 1);
      rx_q.push_back(d);
    end
    sdat_end = sda_t;
    i2c_stop();
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    tick(4);
    if (sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b want 1", sda_t); end
    checks++;
    if (ecr !== 8'h00) begin errors++; $display("FAIL reset_ecr: got %h want 00", ecr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (soft_reset_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", soft_reset_pulse); end
    checks++;
    reset = 1'b0;
    tick(10);
  endtask

  task automatic check_reads(input string name, input logic [7:0] ptr, input int n);
    logic [11:0] s;
    logic [7:0] got, want;
    int nk;
    logic bm, se;
    s = model_snap(touch, m_ecr);
    for (int i = 0; i < n; i++) exp_q.push_back(model_reg(8'(ptr + i), s));
    do_read(ptr, n, nk, bm, se);
    if (nk !== 0) begin errors++; $display("FAIL %s_ack: got %0d nacks want 0", name, nk); end
    checks++;
    if (bm !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, bm); end
    checks++;
    if (se !== 1'b1) begin errors++; $display("FAIL %s_release: sda_t got %b want 1 after NACK", name, se); end
    checks++;
    for (int i = 0; i < n; i++) begin
      got  = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      want = exp_q.pop_front();
      if (got !== want) begin errors++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, got, want); end
      checks++;
    end
  endtask

  task automatic write_reg(input string name, input logic [7:0] a, input logic [7:0] d);
    int nk;
    tx_q = '{d};
    do_write(a, nk);
    model_write(a, d);
    if (nk !== 0) begin errors++; $display("FAIL %s_ack: got %0d nacks want 0", name, nk); end
    checks++;
  endtask

  task automatic test_ecr_write();
    write_reg("ecr_wr", 8'h5E, 8'h8C);
    if (ecr !== 8'h8C) begin errors++; $display("FAIL ecr_value: got %h want 8c", ecr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b want 0", busy); end
    checks++;
    check_reads("ecr_rd", 8'h5E, 1);
  endtask

  task automatic test_status_read();
    touch = 12'hA05;
    check_reads("status", 8'h00, 2);
    write_reg("ecr84", 8'h5E, 8'h84);
    touch = 12'hFFF;
    check_reads("masked", 8'h00, 2);
  endtask

  task automatic test_bad_addr();
    logic a;
    int d0;
    logic [7:0] e0;
    logic bm;
    d0 = drive_cnt;
    e0 = ecr;
    i2c_start();
    put_byte({7'h5B, 1'b0}, a);
    bm = busy;
    put_byte(8'h5E, a);
    put_byte(8'h11, a);
    i2c_stop();
    if (drive_cnt !== d0) begin errors++; $display("FAIL badaddr_drive: got %0d driven cycles want 0", drive_cnt - d0); end
    checks++;
    if (bm !== 1'b0) begin errors++; $display("FAIL badaddr_busy: got %b want 0", bm); end
    checks++;
    if (ecr !== e0) begin errors++; $display("FAIL badaddr_ecr: got %h want %h", ecr, e0); end
    checks++;
  endtask

  task automatic test_soft_reset();
    int p0;
    p0 = pulse_cnt;
    write_reg("srst", 8'h80, 8'h63);
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL srst_pulse: got %0d cycles want 1", pulse_cnt - p0); end
    checks++;
    if (pulse_max !== 1) begin errors++; $display("FAIL srst_width: got %0d want 1", pulse_max); end
    checks++;
    if (ecr !== m_ecr) begin errors++; $display("FAIL srst_ecr: got %h want %h", ecr, m_ecr); end
    checks++;
    write_reg("ecr3c", 8'h5E, 8'h3C);
    p0 = pulse_cnt;
    write_reg("srst62", 8'h80, 8'h62);
    if (pulse_cnt !== p0) begin errors++; $display("FAIL srst62_pulse: got %0d cycles want 0", pulse_cnt - p0); end
    checks++;
    if (ecr !== m_ecr) begin errors++; $display("FAIL srst62_ecr: got %h want %h", ecr, m_ecr); end
    checks++;
  endtask

  task automatic test_back_to_back();
    int nk;
    logic [7:0] y;
    y = 8'($urandom_range(0, 255));
    tx_q = '{8'hC3, y, 8'h5A};
    do_write(8'h5D, nk);
    model_write(8'h5D, 8'hC3);
    model_write(8'h5E, y);
    model_write(8'h5F, 8'h5A);
    if (nk !== 0) begin errors++; $display("FAIL burst_ack: got %0d nacks want 0", nk); end
    checks++;
    if (ecr !== m_ecr) begin errors++; $display("FAIL burst_ecr: got %h want %h", ecr, m_ecr); end
    checks++;
    touch = 12'($urandom_range(0, 4095));
    check_reads("burst_rd", 8'h5D, 3);
    check_reads("wrap_rd", 8'hFF, 3);
  endtask

  task automatic test_reset_mid_read();
    logic a, b;
    int nk;
    write_reg("pre", 8'h5E, 8'h8C);
    tx_q.delete();
    do_write(8'h5E, nk);
    i2c_start();
    put_byte({ADDR_T, 1'b1}, a);
    for (int i = 0; i < 3; i++) get_bit(b);
    if (sda_t !== 1'b0) begin errors++; $display("FAIL midrd_bit4: sda_t got %b want 0", sda_t); end
    checks++;
    reset = 1'b1;
    @(posedge clk_27M);
    #1;
    if (sda_t !== 1'b1) begin errors++; $display("FAIL midrd_release: sda_t got %b want 1", sda_t); end
    checks++;
    tick(3);
    reset = 1'b0;
    m_ecr = 8'h00;
    sda_m = 1'b1;
    tick(10);
    i2c_stop();
    if (ecr !== 8'h00) begin errors++; $display("FAIL midrd_ecr: got %h want 00", ecr); end
    checks++;
    write_reg("post", 8'h5E, 8'h8C);
    touch = 12'($urandom_range(0, 4095));
    check_reads("post_rd", 8'h00, 2);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          write_reg("rnd_ecr", 8'h5E, 8'($urandom_range(0, 255)));
          if (ecr !== m_ecr) begin errors++; $display("FAIL rnd_ecr_val: got %h want %h", ecr, m_ecr); end
          checks++;
        end
        1: begin
          touch = 12'($urandom_range(0, 4095));
          check_reads("rnd_status", 8'h00, 2);
        end
        2: begin
          do a = 8'($urandom_range(2, 255)); while (a == 8'h5E || a == 8'h80);
          write_reg("rnd_other", a, 8'($urandom_range(0, 255)));
          check_reads("rnd_other_rd", a, 1);
        end
        default: begin
          touch = 12'($urandom_range(0, 4095));
          check_reads("rnd_wrap", 8'hFF, 3);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_ecr_write();
    test_status_read();
    test_bad_addr();
    test_soft_reset();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
